// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer
//   Ping-pong input reorder buffer ahead of a radix-2 DIT butterfly network.
//   Samples arrive in natural order and each N = 2^LOG2N frame leaves in
//   bit-reversed index order. Data passes through unmodified.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   in_valid     upstream sample valid
//   in_ready     buffer can take a sample (bank being written is EMPTY)
//   in_data      packed complex sample {re, im}, natural order
//   out_valid    a FULL bank is presented on the output
//   out_ready    downstream accepts the current output
//   out_data     sample at bitrev(read count) of the bank being read
//   out_index    natural-order index of out_data
//   out_last     final sample of the frame
module fft_bitrev_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG2N = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LOG2N-1:0] out_index,
  output logic             out_last
);

  localparam int unsigned      N        = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_e;

  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

  logic [WIDTH-1:0] bank_mem [2][N];

  logic             wr_acc;
  logic             rd_acc;
  logic [LOG2N-1:0] rd_idx;

  assign rd_idx = {<<{rd_cnt_q}};

  always_comb begin
    in_ready  = (state_q[wr_bank_q] == EMPTY);
    out_valid = (state_q[rd_bank_q] == FULL);
    wr_acc    = in_valid && in_ready;
    rd_acc    = out_valid && out_ready;

    out_data  = '0;
    out_index = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data  = bank_mem[rd_bank_q][rd_idx];
      out_index = rd_idx;
      out_last  = (rd_cnt_q == CNT_LAST);
    end
  end

  // A write only ever targets an EMPTY bank and a read only a FULL one, so
  // the two state updates below always hit different banks and both apply.
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;

    if (wr_acc) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      if (wr_cnt_q == CNT_LAST) begin
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
      end
    end

    if (rd_acc) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == CNT_LAST) begin
        state_d[rd_bank_q] = EMPTY;
        rd_bank_d          = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Storage is never cleared; reset only discards it by emptying the bank states.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) begin
      bank_mem[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Testbench for fft_bitrev_buffer: one instance with LOG2N=3 and one with
// LOG2N=1, both checked every cycle against a frame-queue reference model.
module tb_fft_bitrev_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic [31:0] id   [2];
  logic        ordy [2];

  logic        in_ready0, out_valid0, out_last0;
  logic [31:0] out_data0;
  logic [2:0]  out_index0;
  logic        in_ready1, out_valid1, out_last1;
  logic [31:0] out_data1;
  logic [0:0]  out_index1;

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  fft_bitrev_buffer #(.WIDTH(32), .LOG2N(3)) dut (
    .clk(clk), .reset(rst),
    .in_valid(iv[0]), .in_ready(in_ready0), .in_data(id[0]),
    .out_valid(out_valid0), .out_ready(ordy[0]), .out_data(out_data0),
    .out_index(out_index0), .out_last(out_last0)
  );

  fft_bitrev_buffer #(.WIDTH(32), .LOG2N(1)) dut1 (
    .clk(clk), .reset(rst),
    .in_valid(iv[1]), .in_ready(in_ready1), .in_data(id[1]),
    .out_valid(out_valid1), .out_ready(ordy[1]), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1)
  );

  // Reference model: up to 4 frame slots per instance used as a ring;
  // nfull = completed frames not yet drained, head = frame being read.
  logic [31:0] fr [2][4][8];
  int          head  [2];
  int          nfull [2];
  int          wcnt  [2];
  int          rpos  [2];

  // Accepted outputs as seen on the DUT, for the literal expectations.
  logic [31:0] lg0_d[$];
  int          lg0_i[$];
  bit          lg0_l[$];
  logic [31:0] lg1_d[$];
  bit          lg1_l[$];

  int exp_ord [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int rev(input int p, input int lg);
    int r = 0;
    int v = p;
    for (int k = 0; k < lg; k++) begin
      r = r * 2 + v % 2;
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s inst%0d: actual %h required %h at %0t", nm, inst, act, req, $time);
    end
  endtask

  // Compare process
  int          c_lg, c_n, c_idx, c_slot;
  logic        c_v, c_r, c_l, c_wacc, c_racc, c_inc, c_dec;
  logic [31:0] c_d, a_d;
  logic        a_v, a_r, a_l;
  int          a_idx;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      c_lg = (i == 0) ? 3 : 1;
      c_n  = 1 << c_lg;
      c_r  = (nfull[i] < 2);
      c_v  = (nfull[i] > 0);
      c_idx = c_v ? rev(rpos[i], c_lg) : 0;
      c_d  = c_v ? fr[i][head[i]][c_idx] : 32'h0;
      c_l  = c_v && (rpos[i] == c_n - 1);

      a_r   = (i == 0) ? in_ready0  : in_ready1;
      a_v   = (i == 0) ? out_valid0 : out_valid1;
      a_d   = (i == 0) ? out_data0  : out_data1;
      a_l   = (i == 0) ? out_last0  : out_last1;
      a_idx = (i == 0) ? int'(out_index0) : int'(out_index1);

      if (armed) begin
        chk("in_ready",  i, 32'(a_r), 32'(c_r));
        chk("out_valid", i, 32'(a_v), 32'(c_v));
        chk("out_data",  i, a_d, c_d);
        chk("out_index", i, 32'(a_idx), 32'(c_idx));
        chk("out_last",  i, 32'(a_l), 32'(c_l));
      end

      if (rst) begin
        head[i] = 0; nfull[i] = 0; wcnt[i] = 0; rpos[i] = 0;
      end else begin
        c_wacc = iv[i] && c_r;
        c_racc = c_v && ordy[i];
        c_inc  = 1'b0;
        c_dec  = 1'b0;
        if (c_wacc) begin
          c_slot = (head[i] + nfull[i]) % 4;
          fr[i][c_slot][wcnt[i]] = id[i];
          wcnt[i]++;
          if (wcnt[i] == c_n) begin
            wcnt[i] = 0;
            c_inc = 1'b1;
          end
        end
        if (c_racc) begin
          if (i == 0) begin
            lg0_d.push_back(a_d); lg0_i.push_back(a_idx); lg0_l.push_back(a_l);
          end else begin
            lg1_d.push_back(a_d); lg1_l.push_back(a_l);
          end
          if (rpos[i] == c_n - 1) begin
            rpos[i] = 0;
            head[i] = (head[i] + 1) % 4;
            c_dec = 1'b1;
          end else begin
            rpos[i]++;
          end
        end
        nfull[i] = nfull[i] + int'(c_inc) - int'(c_dec);
      end
    end
  end

  // Stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ready(input int i);
    return (i == 0) ? in_ready0 : in_ready1;
  endfunction

  function automatic logic get_valid(input int i);
    return (i == 0) ? out_valid0 : out_valid1;
  endfunction

  // Leaves in_valid high so consecutive sends stream without bubbles.
  // While stalled, in_data carries junk that must be ignored.
  task automatic send(input int i, input logic [31:0] d);
    int n = 0;
    iv[i] = 1'b1;
    while (!get_ready(i) && n < 300) begin
      id[i] = $urandom;
      step();
      n++;
    end
    if (!get_ready(i)) begin
      tests++; fails++;
      $display("FAIL send_timeout inst%0d: in_ready actual 0 required 1", i);
    end
    id[i] = d;
    step();
  endtask

  // mode 0: out_ready held 1, 1: toggling 1,0,1,0, 2: random
  task automatic drain(input int i, input int mode);
    int n = 0;
    while (get_valid(i) && n < 500) begin
      case (mode)
        0:       ordy[i] = 1'b1;
        1:       ordy[i] = (n % 2 == 0);
        default: ordy[i] = 1'($urandom % 2);
      endcase
      step();
      n++;
    end
    if (get_valid(i)) begin
      tests++; fails++;
      $display("FAIL drain_timeout inst%0d: out_valid actual 1 required 0", i);
    end
    ordy[i] = 1'b0;
  endtask

  task automatic check_order(input int base, input logic [15:0] tag);
    if (lg0_i.size() >= base + 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("order_index", 0, 32'(lg0_i[base + j]), 32'(exp_ord[j]));
        chk("order_data",  0, lg0_d[base + j], {tag, 16'(exp_ord[j])});
      end
    end else begin
      chk("order_count", 0, 32'(lg0_i.size()), 32'(base + 8));
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0;
      head[i] = 0; nfull[i] = 0; wcnt[i] = 0; rpos[i] = 0;
    end
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    armed = 1'b1;
    chk("reset_in_ready",  0, 32'(in_ready0), 32'd1);
    chk("reset_out_valid", 0, 32'(out_valid0), 32'd0);

    // Single frame: {re=k, im=-k}
    ordy[0] = 1'b1;
    for (int k = 0; k < 8; k++) send(0, {16'(k), 16'(-k)});
    iv[0] = 1'b0;
    chk("t1_valid_after_last", 0, 32'(out_valid0), 32'd1);
    chk("t1_first_index",      0, 32'(out_index0), 32'd0);
    drain(0, 0);
    chk("t1_count", 0, 32'(lg0_i.size()), 32'd8);
    if (lg0_i.size() == 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("t1_index", 0, 32'(lg0_i[j]), 32'(exp_ord[j]));
        chk("t1_last",  0, 32'(lg0_l[j]), (j == 7) ? 32'd1 : 32'd0);
      end
      chk("t1_sample3", 0, lg0_d[6], 32'h0003_FFFD);
    end

    // Back-to-back frames
    lg0_d.delete(); lg0_i.delete(); lg0_l.delete();
    ordy[0] = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 8; k++) send(0, {16'(f), 16'(k)});
    iv[0] = 1'b0;
    drain(0, 0);
    chk("t2_count", 0, 32'(lg0_i.size()), 32'd32);
    for (int f = 0; f < 4; f++) check_order(f * 8, 16'(f));

    // Full stall
    lg0_d.delete(); lg0_i.delete(); lg0_l.delete();
    ordy[0] = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) send(0, {16'h10 + 16'(f), 16'(k)});
    chk("t3_ready_low_full", 0, 32'(in_ready0), 32'd0);
    id[0] = 32'h0012_0000;
    step(); step(); step();
    chk("t3_still_stalled", 0, 32'(in_ready0), 32'd0);
    ordy[0] = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      step();
      if (r == 7) chk("t3_ready_before_drain", 0, 32'(in_ready0), 32'd0);
      if (r == 8) chk("t3_ready_after_drain",  0, 32'(in_ready0), 32'd1);
    end
    step();
    for (int k = 1; k < 8; k++) send(0, {16'h12, 16'(k)});
    iv[0] = 1'b0;
    drain(0, 0);
    chk("t3_count", 0, 32'(lg0_i.size()), 32'd24);
    for (int f = 0; f < 3; f++) check_order(f * 8, 16'h10 + 16'(f));

    // Downstream back-pressure
    lg0_d.delete(); lg0_i.delete(); lg0_l.delete();
    for (int k = 0; k < 8; k++) send(0, {16'h30, 16'(k)});
    iv[0] = 1'b0;
    drain(0, 1);
    chk("t4_count", 0, 32'(lg0_i.size()), 32'd8);
    check_order(0, 16'h30);

    // Reset mid-operation
    for (int k = 0; k < 8; k++) send(0, {16'h20, 16'(k)});
    for (int k = 0; k < 5; k++) send(0, {16'h21, 16'(k)});
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    step(); step(); step();
    ordy[0] = 1'b0;
    chk("t5_read_pos", 0, 32'(out_index0), 32'd6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_valid_after_reset", 0, 32'(out_valid0), 32'd0);
    chk("t5_ready_after_reset", 0, 32'(in_ready0), 32'd1);
    lg0_d.delete(); lg0_i.delete(); lg0_l.delete();
    for (int k = 0; k < 8; k++) send(0, {16'h22, 16'(k)});
    iv[0] = 1'b0;
    drain(0, 0);
    chk("t5_count", 0, 32'(lg0_i.size()), 32'd8);
    check_order(0, 16'h22);

    // LOG2N=1 corner
    send(1, 32'hAAAA_0001);
    send(1, 32'hBBBB_0002);
    iv[1] = 1'b0;
    drain(1, 0);
    chk("t6_count", 1, 32'(lg1_d.size()), 32'd2);
    if (lg1_d.size() == 2) begin
      chk("t6_first",  1, lg1_d[0], 32'hAAAA_0001);
      chk("t6_second", 1, lg1_d[1], 32'hBBBB_0002);
      chk("t6_last0",  1, 32'(lg1_l[0]), 32'd0);
      chk("t6_last1",  1, 32'(lg1_l[1]), 32'd1);
    end

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        iv[i]   = ($urandom % 4) != 0;
        id[i]   = $urandom;
        ordy[i] = ($urandom % 3) != 0;
      end
      step();
    end
    iv[0] = 1'b0;
    iv[1] = 1'b0;
    drain(0, 2);
    drain(1, 2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
